// File: rtl/if_fetch_if.sv
// Instruction-memory bus between the fetch front end and imem.
// Requests are address-only; responses return in order.
interface if_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int INST_W = 16
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch.sv
// Fetch front end: credit-limited in-order imem requests, pending-PC
// queue, output FIFO toward decode, and branch squash of stale fetches.
module if_fetch #(
  parameter int ADDR_W = 16,
  parameter int INST_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_en,
  input  logic              branch_taken,
  if_fetch_if.master        imem,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pwp_q, pwp_d;
  logic [PW-1:0] prp_q, prp_d;
  logic [PW-1:0] fwp_q, fwp_d;
  logic [PW-1:0] frp_q, frp_d;

  logic [ADDR_W-1:0] pend_q [DEPTH];
  logic [ADDR_W-1:0] fpc_q  [DEPTH];
  logic [INST_W-1:0] fdat_q [DEPTH];

  logic [CW:0] used;
  logic        req;
  logic        gnt;
  logic        rv;
  logic        drop;
  logic        wr;
  logic        rd;

  // Credit covers both in-flight and buffered entries, so a
  // granted request always has a FIFO slot waiting for it.
  assign used = {1'b0, out_q} + {1'b0, cnt_q};
  assign req  = (state_q == RUN) & fetch_en
              & ~branch_taken & (used < CAP);
  assign gnt  = req & imem.imem_gnt;
  assign rv   = imem.imem_rvalid & (out_q != '0);
  assign drop = rv & (branch_taken | (disc_q != '0));
  assign wr   = rv & ~drop;

  assign inst_valid = (cnt_q != '0) & ~branch_taken;
  assign rd         = inst_valid & inst_ready;
  assign inst_data  = fdat_q[frp_q];
  assign inst_pc    = fpc_q[frp_q];

  assign pc_en          = gnt;
  assign imem.imem_req  = req;
  assign imem.imem_addr = req ? pc_addr : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_d  = out_q + CW'(gnt) - CW'(rv);
    disc_d = disc_q;
    cnt_d  = cnt_q + CW'(wr) - CW'(rd);
    pwp_d  = pwp_q + PW'(gnt);
    prp_d  = prp_q + PW'(rv);
    fwp_d  = fwp_q + PW'(wr);
    frp_d  = frp_q + PW'(rd);
    unique case (1'b1)
      branch_taken: begin
        disc_d = out_q - CW'(rv);
        cnt_d  = '0;
        frp_d  = fwp_q;
      end
      (rv && disc_q != '0): begin
        disc_d = disc_q - CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      disc_q  <= '0;
      cnt_q   <= '0;
      pwp_q   <= '0;
      prp_q   <= '0;
      fwp_q   <= '0;
      frp_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      cnt_q   <= cnt_d;
      pwp_q   <= pwp_d;
      prp_q   <= prp_d;
      fwp_q   <= fwp_d;
      frp_q   <= frp_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pend_q[i] <= '0;
      end
    end else if (gnt) begin
      pend_q[pwp_q] <= pc_addr;
    end
  end

  // FIFO storage is cleared on reset so the head reads as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fpc_q[i]  <= '0;
        fdat_q[i] <= '0;
      end
    end else if (wr) begin
      fpc_q[fwp_q]  <= pend_q[prp_q];
      fdat_q[fwp_q] <= imem.imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: imem model plus a scoreboard of expected
// deliveries, pushed on grant and popped on decode handshake.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [15:0] pc_addr;
  logic        pc_en;
  logic        branch_taken;
  logic        inst_valid;
  logic [15:0] inst_data;
  logic [15:0] inst_pc;
  logic        inst_ready;

  if_fetch_if #(.ADDR_W(16), .INST_W(16)) imem ();

  if_fetch #(.ADDR_W(16), .INST_W(16), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en     (fetch_en),
    .pc_addr      (pc_addr),
    .pc_en        (pc_en),
    .branch_taken (branch_taken),
    .imem         (imem),
    .inst_valid   (inst_valid),
    .inst_data    (inst_data),
    .inst_pc      (inst_pc),
    .inst_ready   (inst_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int grants = 0;
  int deliv = 0;

  bit fe, rdy, br, mem_en, gnt_en;
  bit watch_first;
  logic [15:0] pc, tgt, first_pc;
  logic [15:0] memq[$];
  logic [15:0] expq[$];

  logic        s_req, s_pcen, s_iv;
  logic [15:0] s_addr;

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return {~a[7:0], a[15:8]} ^ 16'h1234;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    logic [15:0] e;
    fetch_en     = fe;
    inst_ready   = rdy;
    branch_taken = br;
    pc_addr      = pc;
    imem.imem_gnt    = gnt_en;
    imem.imem_rvalid = mem_en && memq.size() > 0;
    imem.imem_rdata  = memq.size() > 0 ? mdata(memq[0]) : 16'h0;
    @(negedge clk);
    s_req  = imem.imem_req;
    s_pcen = pc_en;
    s_iv   = inst_valid;
    s_addr = imem.imem_addr;
    if (s_req) chk("imem_addr", 32'(s_addr), 32'(pc));
    if (pc_en) begin
      grants++;
      memq.push_back(pc);
      expq.push_back(pc);
    end
    if (inst_valid && inst_ready) begin
      if (expq.size() == 0) begin
        chk("spurious_inst", 32'(expq.size()), 32'd1);
      end else begin
        e = expq.pop_front();
        chk("inst_pc", 32'(inst_pc), 32'(e));
        chk("inst_data", 32'(inst_data), 32'(mdata(e)));
        deliv++;
        if (watch_first) begin
          first_pc    = inst_pc;
          watch_first = 1'b0;
        end
      end
    end
    if (imem.imem_rvalid) void'(memq.pop_front());
    if (br) expq.delete();
    if (br) pc = tgt;
    else if (pc_en) pc = pc + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    br = 1'b0; fe = 1'b0; rdy = 1'b1; mem_en = 1'b1;
    repeat (8) cyc();
    chk("drained", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    int d0;
    bit any_iv;
    rst = 1'b0;
    fe = 0; rdy = 0; br = 0; mem_en = 0; gnt_en = 1;
    pc = 16'h0; tgt = 16'h0; first_pc = 16'hffff; watch_first = 0;
    fetch_en = 0; inst_ready = 0; branch_taken = 0; pc_addr = 0;
    imem.imem_gnt = 0; imem.imem_rvalid = 0; imem.imem_rdata = 0;

    repeat (3) begin
      cyc();
      chk("rst_req", 32'(s_req), 32'd0);
      chk("rst_pcen", 32'(s_pcen), 32'd0);
      chk("rst_addr", 32'(s_addr), 32'd0);
      chk("rst_iv", 32'(s_iv), 32'd0);
      chk("rst_data", 32'(inst_data), 32'd0);
      chk("rst_pc", 32'(inst_pc), 32'd0);
    end

    // Startup and streaming.
    rst = 1'b1; fe = 1; rdy = 1; mem_en = 1;
    cyc();
    chk("req_idle", 32'(s_req), 32'd0);
    cyc();
    chk("req_first", 32'(s_req), 32'd1);
    chk("addr_first", 32'(s_addr), 32'd0);
    repeat (12) begin
      cyc();
      chk("pc_en_stream", 32'(s_pcen), 32'd1);
    end
    drain();
    chk("stream_deliv", 32'(deliv), 32'(grants));

    // Backpressure.
    grants = 0; fe = 1; rdy = 0;
    repeat (10) cyc();
    chk("bp_grants", 32'(grants), 32'd4);
    chk("bp_req_low", 32'(s_req), 32'd0);
    chk("bp_valid", 32'(s_iv), 32'd1);
    rdy = 1; grants = 0; d0 = deliv;
    repeat (8) cyc();
    chk("bp_drain", 32'(deliv - d0 >= 4), 32'd1);
    chk("bp_resume", 32'(grants > 0), 32'd1);
    drain();

    // Branch with 2 outstanding and 1 buffered.
    rdy = 0; mem_en = 0; fe = 1;
    repeat (3) cyc();
    fe = 0; mem_en = 1;
    cyc();
    mem_en = 0; br = 1; tgt = 16'h0008;
    cyc();
    chk("br_iv", 32'(s_iv), 32'd0);
    chk("br_pcen", 32'(s_pcen), 32'd0);
    br = 0; fe = 1; mem_en = 1; rdy = 1; watch_first = 1;
    cyc();
    chk("br_flushed", 32'(s_iv), 32'd0);
    repeat (11) cyc();
    chk("br_first_pc", 32'(first_pc), 32'h0008);
    drain();

    // Branch colliding with the only response.
    rdy = 1; mem_en = 0; fe = 1;
    cyc();
    fe = 0; mem_en = 1; br = 1; tgt = 16'h0020;
    cyc();
    chk("col_iv", 32'(s_iv), 32'd0);
    br = 0; fe = 1; watch_first = 1; first_pc = 16'hffff;
    repeat (8) cyc();
    chk("col_first_pc", 32'(first_pc), 32'h0020);
    drain();

    // Reset with 3 outstanding and 1 buffered.
    rdy = 0; fe = 1; mem_en = 0;
    cyc();
    mem_en = 1;
    cyc();
    mem_en = 0;
    repeat (2) cyc();
    chk("mr_pre_iv", 32'(s_iv), 32'd1);
    chk("mr_pre_out", 32'(memq.size()), 32'd3);
    rst = 1'b0;
    #1;
    chk("mr_req", 32'(imem.imem_req), 32'd0);
    chk("mr_pcen", 32'(pc_en), 32'd0);
    chk("mr_addr", 32'(imem.imem_addr), 32'd0);
    chk("mr_iv", 32'(inst_valid), 32'd0);
    chk("mr_data", 32'(inst_data), 32'd0);
    chk("mr_pc", 32'(inst_pc), 32'd0);
    expq.delete();
    fe = 0; rdy = 1;
    repeat (2) cyc();
    rst = 1'b1; mem_en = 1; any_iv = 0;
    repeat (6) begin
      cyc();
      any_iv |= s_iv;
    end
    chk("mr_late_iv", 32'(any_iv), 32'd0);
    chk("mr_late_req", 32'(s_req), 32'd0);
    memq.delete();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch front end between `if_pc` and instruction memory. Turns the current PC into in-order memory requests and pulses `pc_en` once per accepted request. Buffers returned instructions with their PC in a small FIFO toward decode, and squashes in-flight and buffered fetches when a branch is taken.

## Interface
- `ADDR_W`, 16, PC / instruction-address width (matches `if_pc`).
- `INST_W`, 16, instruction word width.
- `DEPTH`, 4, output FIFO entries and the cap on requests in flight; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `fetch_en`  in  1  high = issue new requests; low = issue none, but let outstanding ones complete.
- `pc_addr`  in  ADDR_W  current PC from `if_pc`.
- `pc_en`  out  1  advance PC; combinational, equals `imem_req & imem_gnt`.
- `branch_taken`  in  1  flush; `if_pc` loads its branch address in the same cycle.
- `imem_req`  out  1  fetch request; combinational.
- `imem_addr`  out  ADDR_W  equals `pc_addr`.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response valid; responses return in order, ≥1 cycle after grant.
- `imem_rdata`  in  INST_W  instruction word.
- `inst_valid`  out  1  instruction available to decode.
- `inst_data`  out  INST_W  head instruction.
- `inst_pc`  out  ADDR_W  address of the head instruction.
- `inst_ready`  in  1  decode accepts the head when `inst_valid` is also high.

## Operation
- **FSM.**
  - `IDLE`: reset state, no requests. Moves to `RUN` on the first clock after `rst` deasserts.
  - `RUN`: normal operation. Returns to `IDLE` only on reset.
- **Credit.** `imem_req = RUN & fetch_en & !branch_taken & (outstanding + fifo_count < DEPTH)`.
  - A granted request can never overflow the FIFO.
- **Pending-address queue.**
  - On grant, `pc_addr` is pushed.
  - On `imem_rvalid`, the head is popped and paired with `imem_rdata`.
  - Queue holds ≤`DEPTH` entries.
- **Outstanding counter.** +1 on grant, −1 on `rvalid`, net 0 when both occur in the same cycle.
- **Discard counter.**
  - On `branch_taken`, it is loaded with the outstanding count. If `rvalid` arrives in the same cycle, load outstanding − 1.
  - While discard > 0, each response is dropped (queue head popped, FIFO not written) and discard decrements.
- **Output FIFO.**
  - Written with {`rdata`, paired addr} on a non-discarded response.
  - Read on `inst_valid & inst_ready`.
  - Simultaneous write and read leaves `fifo_count` unchanged.
- **Branch flush.** In the `branch_taken` cycle:
  - FIFO is emptied.
  - `inst_valid` is forced low, so no handshake completes.
  - `imem_req` is low, so `pc_en` is low.
  - A response arriving that cycle is discarded.
- **Protocol errors.**
  - `imem_rvalid` with outstanding = 0 is ignored; no state changes.
  - `imem_gnt` without `imem_req` is ignored.
- **Counter widths.** All counters are `$clog2(DEPTH+1)` bits and never wrap; credit prevents it.

## Timing
- **Reset values.** While `rst` = 0, all outputs are 0: `pc_en`, `imem_req`, `imem_addr`, `inst_valid`, `inst_data`, `inst_pc`. All counters are 0 and the FSM is `IDLE`.
  - `imem_addr` is gated to 0 when `imem_req` = 0.
- **First request.** Earliest `imem_req` is the 2nd rising edge after `rst` deasserts (one `IDLE` cycle).
- **Fetch latency.**
  - Grant at cycle t → `pc_addr` advances at t+1.
  - Response at cycle r → `inst_valid` at r+1.
  - `inst_valid`, `inst_data` and `inst_pc` are registered FIFO-head outputs, except for the flush gating of `inst_valid`.
- **Throughput.** One instruction per cycle with a zero-wait memory and `inst_ready` held high.
- **Flush timing.**
  - `branch_taken` at cycle b → first request to the target PC at b+1.
  - Its instruction reaches decode only after all discards drain.
- **Reset mid-operation.** Asynchronous; immediately clears all state. In-flight responses after reset are ignored (outstanding = 0).
- **Stall.** `fetch_en` low or decode stalled: the FIFO fills to `DEPTH` − outstanding, then `imem_req` stays low until credit frees.

## Test plan
- **Reset/startup.** Hold `rst` = 0 for 3 cycles with `pc_addr` = 0 → all outputs 0.
  - Release `rst` → `imem_req` rises on the 2nd edge with `imem_addr` = 0x0000.
- **Streaming.** Grant every cycle, 1-cycle response latency, `inst_ready` = 1, `pc_addr` stepping 0, 1, 2…
  - Required: `inst_pc` = 0, 1, 2… on consecutive cycles and `inst_data` matches memory.
  - Required: `pc_en` high every cycle after the first.
- **Backpressure.** `inst_ready` = 0 with `DEPTH` = 4 → exactly 4 grants, then `imem_req` = 0.
  - Raise `inst_ready` → 4 instructions drain in order, then requests resume.
- **Branch with 2 outstanding.** Pulse `branch_taken` while 2 are outstanding and the FIFO holds 1; `pc_addr` becomes 0x0008.
  - Required: the FIFO empties and `inst_valid` is 0 in the branch cycle.
  - Required: the next 2 responses are dropped.
  - Required: the first delivered `inst_pc` = 0x0008.
- **Branch colliding with a response.** `branch_taken` and `imem_rvalid` in the same cycle with 1 outstanding → that response is dropped, discard count = 0, and the next response is delivered.
- **Mid-flight reset.** Assert `rst` with 3 outstanding → outputs 0 immediately. A late `imem_rvalid` after release produces no `inst_valid`.
